// File: rtl/serial_mac.sv
// Serial multiply-accumulate over N_TAPS sample/coefficient pairs per frame.
// Define MAC_SATURATE_EN to clamp the accumulator on overflow instead of wrapping.
module serial_mac #(
   parameter int DATA_WIDTH = 16,
   parameter int COEF_WIDTH = 16,
   parameter int ACC_WIDTH  = 40,
   parameter int N_TAPS     = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic signed [DATA_WIDTH-1:0] in_data,
   input  logic signed [COEF_WIDTH-1:0] in_coef,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic signed [ACC_WIDTH-1:0]  out_acc,
   output logic                         out_ovr
);

   localparam int PW = DATA_WIDTH + COEF_WIDTH;
   localparam int CW = $clog2(N_TAPS + 1);
   localparam logic [CW-1:0] LAST = CW'(N_TAPS - 1);
   localparam logic signed [ACC_WIDTH-1:0] ACC_MAX =
      {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] ACC_MIN =
      {1'b1, {(ACC_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE,
      ACC,
      HOLD
   } state_t;

   state_t state_q, state_d;

   logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
   logic signed [ACC_WIDTH-1:0] out_acc_q, out_acc_d;
   logic signed [ACC_WIDTH-1:0] prod_ext, sum, acc_add;
   logic signed [PW-1:0]        prod;
   logic [CW-1:0]               cnt_q, cnt_d;
   logic ovr_q, ovr_d;
   logic out_ovr_q, out_ovr_d;
   logic out_valid_q, out_valid_d;
   logic hs, of;

   assign in_ready  = (state_q != HOLD);
   assign out_valid = out_valid_q;
   assign out_acc   = out_acc_q;
   assign out_ovr   = out_ovr_q;

   assign hs       = in_valid & in_ready;
   assign prod     = in_data * in_coef;
   assign prod_ext = ACC_WIDTH'(prod);
   assign sum      = acc_q + prod_ext;

   // Same-sign addends with a flipped result sign.
   assign of = (acc_q[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
               (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);

`ifdef MAC_SATURATE_EN
   assign acc_add = !of ? sum :
                    (acc_q[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX);
`else
   assign acc_add = sum;
`endif

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      ovr_d       = ovr_q;
      out_acc_d   = out_acc_q;
      out_ovr_d   = out_ovr_q;
      out_valid_d = out_valid_q;
      unique case (state_q)
         IDLE: begin
            if (hs) begin
               acc_d   = prod_ext;
               ovr_d   = 1'b0;
               cnt_d   = CW'(1);
               state_d = ACC;
            end
         end
         ACC: begin
            if (hs) begin
               acc_d = acc_add;
               ovr_d = ovr_q | of;
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == LAST) begin
                  state_d     = HOLD;
                  out_acc_d   = acc_add;
                  out_ovr_d   = ovr_q | of;
                  out_valid_d = 1'b1;
               end
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
            end
         end
         default: begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         ovr_q       <= 1'b0;
         out_acc_q   <= '0;
         out_ovr_q   <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         ovr_q       <= ovr_d;
         out_acc_q   <= out_acc_d;
         out_ovr_q   <= out_ovr_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_serial_mac.sv
// Scoreboard bench for serial_mac: 4-tap frames on 20- and 16-bit
// accumulators driven in lockstep from the same stimulus.
module tb_serial_mac;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in_valid = 1'b0;
   logic out_ready = 1'b1;
   logic signed [7:0] in_data = '0;
   logic signed [7:0] in_coef = '0;

   logic in_ready20, out_valid20, out_ovr20;
   logic in_ready16, out_valid16, out_ovr16;
   logic signed [19:0] out_acc20;
   logic signed [15:0] out_acc16;

   typedef struct {
      longint a20;
      bit     o20;
      longint a16;
      bit     o16;
   } exp_t;

   exp_t sbq[$];
   int vectors = 0;
   int miscompares = 0;

   serial_mac #(
      .DATA_WIDTH(8), .COEF_WIDTH(8), .ACC_WIDTH(20), .N_TAPS(4)
   ) dut20 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready20),
      .in_data(in_data), .in_coef(in_coef),
      .out_valid(out_valid20), .out_ready(out_ready),
      .out_acc(out_acc20), .out_ovr(out_ovr20)
   );

   serial_mac #(
      .DATA_WIDTH(8), .COEF_WIDTH(8), .ACC_WIDTH(16), .N_TAPS(4)
   ) dut16 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready16),
      .in_data(in_data), .in_coef(in_coef),
      .out_valid(out_valid16), .out_ready(out_ready),
      .out_acc(out_acc16), .out_ovr(out_ovr16)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   function automatic longint step(input longint acc, input longint p,
                                   input int w, output bit of);
      longint one, hi, lo, s;
      one = 1;
      hi = (one << (w - 1)) - 1;
      lo = -(hi + 1);
      s = acc + p;
      of = (s > hi) || (s < lo);
`ifdef MAC_SATURATE_EN
      if (s > hi) s = hi;
      else if (s < lo) s = lo;
`else
      if (s > hi) s = s - 2 * (hi + 1);
      else if (s < lo) s = s + 2 * (hi + 1);
`endif
      return s;
   endfunction

   task automatic push_model(input int d[4], input int c[4]);
      exp_t e;
      bit of;
      longint p;
      p = longint'(d[0] * c[0]);
      e.a20 = p; e.a16 = p; e.o20 = 1'b0; e.o16 = 1'b0;
      for (int i = 1; i < 4; i++) begin
         p = longint'(d[i] * c[i]);
         e.a20 = step(e.a20, p, 20, of);
         e.o20 = e.o20 | of;
         e.a16 = step(e.a16, p, 16, of);
         e.o16 = e.o16 | of;
      end
      sbq.push_back(e);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_frame(input int d[4], input int c[4], input int g[4]);
      int n;
      push_model(d, c);
      for (int i = 0; i < 4; i++) begin
         repeat (g[i]) begin
            in_valid = 1'b0;
            cyc();
         end
         in_valid = 1'b1;
         in_data = 8'(d[i]);
         in_coef = 8'(c[i]);
         n = 0;
         while (!(in_ready20 && in_ready16) && n < 50) begin
            cyc();
            n++;
         end
         if (n >= 50) begin
            vectors++;
            miscompares++;
            $display("FAIL in_ready_timeout tap=%0d got=%b/%b want=1",
                     i, in_ready20, in_ready16);
         end
         cyc();
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output bit ok);
      int n;
      n = 0;
      while (!(out_valid20 && out_valid16) && n < 50) begin
         cyc();
         n++;
      end
      ok = (n < 50);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) cyc();
      vectors++;
      if ({out_valid20, out_valid16, out_acc20, out_acc16,
           out_ovr20, out_ovr16, in_ready20, in_ready16} !== {38'd0, 2'b11}) begin
         miscompares++;
         $display("FAIL reset_state got v=%b%b acc=%0d/%0d ovr=%b%b rdy=%b%b want 0 0 0 rdy=11",
                  out_valid20, out_valid16, out_acc20, out_acc16,
                  out_ovr20, out_ovr16, in_ready20, in_ready16);
      end
      rst_n = 1'b1;
      cyc();
      vectors++;
      if ({in_ready20, in_ready16, out_valid20, out_valid16} !== 4'b1100) begin
         miscompares++;
         $display("FAIL post_reset_ready got rdy=%b%b v=%b%b want rdy=11 v=00",
                  in_ready20, in_ready16, out_valid20, out_valid16);
      end
   endtask

   task automatic test_basic();
      exp_t e;
      drive_frame('{1, 2, 3, 4}, '{1, 1, 1, 1}, '{0, 0, 0, 0});
      vectors++;
      if ({out_valid20, out_valid16} !== 2'b11) begin
         miscompares++;
         $display("FAIL basic_latency got out_valid=%b%b want 11",
                  out_valid20, out_valid16);
      end
      e = sbq.pop_front();
      vectors++;
      if ({out_acc20, out_ovr20, out_acc16, out_ovr16} !==
          {e.a20[19:0], e.o20, e.a16[15:0], e.o16}) begin
         miscompares++;
         $display("FAIL basic_result got %0d/%b %0d/%b want %0d/%b %0d/%b",
                  out_acc20, out_ovr20, out_acc16, out_ovr16,
                  e.a20, e.o20, e.a16, e.o16);
      end
      cyc();
      vectors++;
      if ({out_valid20, out_valid16, in_ready20, in_ready16} !== 4'b0011) begin
         miscompares++;
         $display("FAIL basic_release got v=%b%b rdy=%b%b want v=00 rdy=11",
                  out_valid20, out_valid16, in_ready20, in_ready16);
      end
   endtask

   task automatic test_backpressure();
      exp_t e;
      out_ready = 1'b0;
      drive_frame('{1, 2, 3, 4}, '{1, 1, 1, 1}, '{0, 0, 0, 0});
      e = sbq.pop_front();
      for (int k = 0; k < 5; k++) begin
         vectors++;
         if ({out_valid20, out_valid16, in_ready20, in_ready16,
              out_acc20, out_acc16} !==
             {4'b1100, e.a20[19:0], e.a16[15:0]}) begin
            miscompares++;
            $display("FAIL hold_cycle%0d got v=%b%b rdy=%b%b acc=%0d/%0d want v=11 rdy=00 acc=%0d/%0d",
                     k, out_valid20, out_valid16, in_ready20, in_ready16,
                     out_acc20, out_acc16, e.a20, e.a16);
         end
         cyc();
      end
      out_ready = 1'b1;
      cyc();
      vectors++;
      if ({out_valid20, out_valid16, in_ready20, in_ready16} !== 4'b0011) begin
         miscompares++;
         $display("FAIL hold_release got v=%b%b rdy=%b%b want v=00 rdy=11",
                  out_valid20, out_valid16, in_ready20, in_ready16);
      end
   endtask

   task automatic test_overflow();
      exp_t e;
      bit ok;
      drive_frame('{-128, -128, -128, -128}, '{-128, -128, -128, -128},
                  '{0, 0, 0, 0});
      wait_out(ok);
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL overflow_timeout got out_valid=0 want 1");
      end
      e = sbq.pop_front();
      vectors++;
      if ({out_acc20, out_ovr20, out_acc16, out_ovr16} !==
          {e.a20[19:0], e.o20, e.a16[15:0], e.o16}) begin
         miscompares++;
         $display("FAIL overflow_result got %0d/%b %0d/%b want %0d/%b %0d/%b",
                  out_acc20, out_ovr20, out_acc16, out_ovr16,
                  e.a20, e.o20, e.a16, e.o16);
      end
      cyc();
   endtask

   task automatic test_gaps();
      exp_t e;
      bit ok;
      drive_frame('{1, 2, 3, 4}, '{1, 1, 1, 1}, '{0, 2, 1, 0});
      wait_out(ok);
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL gaps_timeout got out_valid=0 want 1");
      end
      e = sbq.pop_front();
      vectors++;
      if ({out_acc20, out_ovr20, out_acc16, out_ovr16} !==
          {e.a20[19:0], e.o20, e.a16[15:0], e.o16}) begin
         miscompares++;
         $display("FAIL gaps_result got %0d/%b %0d/%b want %0d/%b %0d/%b",
                  out_acc20, out_ovr20, out_acc16, out_ovr16,
                  e.a20, e.o20, e.a16, e.o16);
      end
      cyc();
   endtask

   task automatic test_mid_reset();
      exp_t e;
      bit ok;
      in_valid = 1'b1;
      in_data = 8'sd7;
      in_coef = 8'sd9;
      cyc();
      cyc();
      in_valid = 1'b0;
      rst_n = 1'b0;
      cyc();
      vectors++;
      if ({out_valid20, out_valid16, out_acc20, out_acc16} !== 38'd0) begin
         miscompares++;
         $display("FAIL midreset_state got v=%b%b acc=%0d/%0d want 0 0",
                  out_valid20, out_valid16, out_acc20, out_acc16);
      end
      rst_n = 1'b1;
      cyc();
      drive_frame('{5, 5, 5, 5}, '{2, 2, 2, 2}, '{0, 0, 0, 0});
      wait_out(ok);
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL midreset_timeout got out_valid=0 want 1");
      end
      e = sbq.pop_front();
      vectors++;
      if ({out_acc20, out_ovr20, out_acc16, out_ovr16} !==
          {e.a20[19:0], e.o20, e.a16[15:0], e.o16}) begin
         miscompares++;
         $display("FAIL midreset_result got %0d/%b %0d/%b want %0d/%b %0d/%b",
                  out_acc20, out_ovr20, out_acc16, out_ovr16,
                  e.a20, e.o20, e.a16, e.o16);
      end
      cyc();
   endtask

   task automatic test_back_to_back();
      exp_t e;
      bit ok;
      drive_frame('{-128, -128, -128, -128}, '{-128, -128, -128, -128},
                  '{0, 0, 0, 0});
      e = sbq.pop_front();
      vectors++;
      if ({out_valid20, out_valid16, out_acc16, out_ovr16} !==
          {2'b11, e.a16[15:0], e.o16}) begin
         miscompares++;
         $display("FAIL b2b_first got v=%b%b acc16=%0d ovr16=%b want v=11 %0d/%b",
                  out_valid20, out_valid16, out_acc16, out_ovr16, e.a16, e.o16);
      end
      drive_frame('{1, 1, 1, 1}, '{-1, -1, -1, -1}, '{0, 0, 0, 0});
      wait_out(ok);
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL b2b_timeout got out_valid=0 want 1");
      end
      e = sbq.pop_front();
      vectors++;
      if ({out_acc20, out_ovr20, out_acc16, out_ovr16} !==
          {e.a20[19:0], e.o20, e.a16[15:0], e.o16}) begin
         miscompares++;
         $display("FAIL b2b_second got %0d/%b %0d/%b want %0d/%b %0d/%b",
                  out_acc20, out_ovr20, out_acc16, out_ovr16,
                  e.a20, e.o20, e.a16, e.o16);
      end
      cyc();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_overflow();
      test_gaps();
      test_mid_reset();
      test_back_to_back();
      vectors++;
      if (sbq.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_leftover got %0d want 0", sbq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/serial_mac.md
SERIAL_MAC -- requirements
Module: serial_mac

Interface
REQ-001 Parameters SHALL be, one per line:
  DATA_WIDTH, 16, signed sample width
  COEF_WIDTH, 16, signed coefficient width
  ACC_WIDTH, 40, signed accumulator width (SHALL be >= DATA_WIDTH+COEF_WIDTH)
  N_TAPS, 8, pairs per frame (SHALL be >= 2)
REQ-002 Ports SHALL be, one per line:
  clk  input  1  sole clock, rising edge
  rst_n  input  1  asynchronous active-low reset
  in_valid  input  1  sample/coef pair valid
  in_ready  output  1  block accepts pair
  in_data  input  DATA_WIDTH  signed sample
  in_coef  input  COEF_WIDTH  signed coefficient
  out_valid  output  1  frame result valid
  out_ready  input  1  downstream accepts result
  out_acc  output  ACC_WIDTH  signed dot product, frac bits = sample frac + coef frac
  out_ovr  output  1  accumulator overflow occurred in this frame
REQ-003 One clock; reset SHALL be asynchronous and active-low.

Function
REQ-004 A pair SHALL be accepted on a rising edge with in_valid=1 and in_ready=1 (handshake).
REQ-005 FSM states SHALL be IDLE (no pair of the current frame accepted), ACC (1..N_TAPS-1 pairs accepted) and HOLD (result presented).
REQ-006 in_ready SHALL be 1 in IDLE and ACC, and 0 in HOLD.
REQ-007 Product SHALL be the full-width signed product in_data*in_coef, sign-extended to ACC_WIDTH.
REQ-008 A handshake in IDLE SHALL load acc with the product, clear the overflow flag, set tap_cnt=1, and go to ACC.
REQ-009 A handshake in ACC SHALL add the product to acc and increment tap_cnt.
REQ-010 The handshake that makes tap_cnt reach N_TAPS SHALL go to HOLD; out_valid SHALL be 1 the next cycle (one-cycle latency after the last handshake).
REQ-011 Overflow SHALL be detected when both addends have the same sign and the sum sign differs; detection SHALL set a sticky flag for the frame.
REQ-012 In HOLD, out_acc and out_ovr SHALL be stable until out_valid=1 and out_ready=1; the state SHALL then return to IDLE on the next cycle, with no same-cycle pair acceptance.
REQ-013 Cycles with in_valid=0 SHALL leave acc, tap_cnt and the state unchanged (gaps allowed).
REQ-014 out_acc and out_ovr SHALL be registered; they are don't-care-free: both SHALL hold last-frame values outside HOLD.

Reset
REQ-015 While rst_n=0, the state SHALL be IDLE and acc=0, tap_cnt=0, out_valid=0, out_acc=0, out_ovr=0; in_ready SHALL be 1 after reset release.
REQ-016 Reset asserted mid-frame SHALL discard the partial frame; the first handshake after release SHALL start a new frame.

Configuration
REQ-017 Macro MAC_SATURATE_EN: defined -> on overflow, acc SHALL clamp to the signed max/min of ACC_WIDTH (by the sign of the addends), and later adds SHALL continue from the clamped value.
REQ-018 MAC_SATURATE_EN undefined -> acc SHALL wrap in two's-complement; out_ovr SHALL be set in both builds.

Verification (DATA_WIDTH=8, COEF_WIDTH=8, N_TAPS=4)
REQ-019 ACC_WIDTH=20, data {1,2,3,4}, coef {1,1,1,1}, back-to-back -> out_acc=10, out_ovr=0, out_valid high 1 cycle after the 4th handshake.
REQ-020 Same frame, out_ready=0 for 5 cycles -> out_acc holds 10, in_ready=0 throughout; after out_ready=1 handshake, IDLE next cycle with in_ready=1.
REQ-021 ACC_WIDTH=16, data=-128, coef=-128 x4 -> without macro: out_acc=0, out_ovr=1; with MAC_SATURATE_EN: out_acc=32767, out_ovr=1.
REQ-022 in_valid toggled 1,0,0,1,0,1,1 over the frame of REQ-019 -> out_acc=10, same as back-to-back.
REQ-023 rst_n pulsed low after 2 handshakes, then a full frame data {5,5,5,5}, coef {2,2,2,2} -> out_acc=40, out_ovr=0.
REQ-024 Two consecutive frames, the first overflowing and the second data {1,1,1,1}, coef {-1,-1,-1,-1} -> second out_acc=-4, out_ovr=0 (flag cleared per frame).
